// File: rtl/pmod_wave_sequencer_if.sv
// pmod_wave_sequencer_if: step-table write port (valid/ready).
// master writes entries, slave (sequencer) accepts them.
interface pmod_wave_sequencer_if #(
  parameter int CH    = 8,
  parameter int CNT_W = 24,
  parameter int REP_W = 8,
  parameter int STEPS = 4
);
  localparam int SW = $clog2(STEPS);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [SW-1:0]    cfg_addr;
  logic [CNT_W-1:0] cfg_last;
  logic [CNT_W-1:0] cfg_high;
  logic [CH-1:0]    cfg_mask;
  logic [REP_W-1:0] cfg_rep;

  modport master (
    output cfg_valid,
    output cfg_addr,
    output cfg_last,
    output cfg_high,
    output cfg_mask,
    output cfg_rep,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_addr,
    input  cfg_last,
    input  cfg_high,
    input  cfg_mask,
    input  cfg_rep,
    output cfg_ready
  );
endinterface

// File: rtl/pmod_wave_sequencer.sv
// pmod_wave_sequencer: step-table driven square waves on PMOD pins.
// Define WAVE_SEQ_LOOP_EN to wrap to step 0 instead of stopping.
module pmod_wave_sequencer #(
  parameter int CH    = 8,
  parameter int CNT_W = 24,
  parameter int REP_W = 8,
  parameter int STEPS = 4,
  localparam int SW   = $clog2(STEPS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pmod_wave_sequencer_if.slave cfg,
  input  logic [SW-1:0]        last_step,
  input  logic                 start,
  input  logic                 stop,
  output logic                 busy,
  output logic [SW-1:0]        step,
  output logic                 done,
  output logic [CH-1:0]        pmod
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [SW-1:0]    ONE_S = SW'(1);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
  localparam logic [REP_W-1:0] ONE_R = REP_W'(1);

  typedef struct packed {
    logic [CNT_W-1:0] last;
    logic [CNT_W-1:0] high;
    logic [CH-1:0]    mask;
    logic [REP_W-1:0] rep;
  } ent_t;

  logic [0:0]       state_q, state_d;
  ent_t             tbl_q [STEPS];
  ent_t             tbl_d [STEPS];
  ent_t             cur_q, cur_d;
  ent_t             wr_ent;
  logic [SW-1:0]    step_q, step_d;
  logic [SW-1:0]    ls_q, ls_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [CH-1:0]    pmod_q, pmod_d;
  logic             done_q, done_d;
  logic             idle;
  logic             pin_on;
  logic             wrap;
  logic             step_end;

  assign idle          = state_q == S_IDLE;
  assign cfg.cfg_ready = idle;
  assign busy          = state_q == S_RUN;
  assign step          = step_q;
  assign done          = done_q;
  assign pmod          = pmod_q;

  assign wr_ent = {cfg.cfg_last, cfg.cfg_high,
                   cfg.cfg_mask, cfg.cfg_rep};

  assign pin_on   = phase_q < cur_q.high;
  assign wrap     = phase_q == cur_q.last;
  assign step_end = wrap && (rep_q == cur_q.rep);

  always_comb begin
    tbl_d   = tbl_q;
    state_d = state_q;
    cur_d   = cur_q;
    step_d  = step_q;
    ls_d    = ls_q;
    phase_d = phase_q;
    rep_d   = rep_q;
    pmod_d  = '0;
    done_d  = 1'b0;

    // table write lands before the entry-0 load (write-through)
    if (idle && cfg.cfg_valid) tbl_d[cfg.cfg_addr] = wr_ent;

    unique case (1'b1)
      state_q == S_IDLE: begin
        if (start && !stop) begin
          state_d = S_RUN;
          ls_d    = last_step;
          cur_d   = tbl_d[0];
          step_d  = '0;
          phase_d = '0;
          rep_d   = '0;
        end
      end
      state_q == S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          pmod_d = cur_q.mask & {CH{pin_on}};
          if (step_end) begin
            phase_d = '0;
            rep_d   = '0;
            if (step_q != ls_q) begin
              step_d = step_q + ONE_S;
              cur_d  = tbl_q[step_q + ONE_S];
            end else begin
              done_d = 1'b1;
`ifdef WAVE_SEQ_LOOP_EN
              step_d = '0;
              cur_d  = tbl_q[0];
`else
              state_d = S_IDLE;
`endif
            end
          end else if (wrap) begin
            phase_d = '0;
            rep_d   = rep_q + ONE_R;
          end else begin
            phase_d = phase_q + ONE_C;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      for (int i = 0; i < STEPS; i++) tbl_q[i] <= '0;
      cur_q   <= '0;
      step_q  <= '0;
      ls_q    <= '0;
      phase_q <= '0;
      rep_q   <= '0;
      pmod_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tbl_q   <= tbl_d;
      cur_q   <= cur_d;
      step_q  <= step_d;
      ls_q    <= ls_d;
      phase_q <= phase_d;
      rep_q   <= rep_d;
      pmod_q  <= pmod_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_pmod_wave_sequencer.sv
// tb_pmod_wave_sequencer: directed runs checked every cycle
// against a flattened-waveform model of the step table.
module tb_pmod_wave_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] last_step = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       busy;
  logic       done;
  logic [1:0] step;
  logic [7:0] pmod;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  pmod_wave_sequencer_if bus ();

  pmod_wave_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg       (bus),
    .last_step (last_step),
    .start     (start),
    .stop      (stop),
    .busy      (busy),
    .step      (step),
    .done      (done),
    .pmod      (pmod)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pmod;
    logic       busy;
    logic       done;
    logic [1:0] step;
    bit         sv;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] m_last [4];
  logic [23:0] m_high [4];
  logic [7:0]  m_mask [4];
  logic [7:0]  m_rep  [4];
  logic [7:0]  wave[$];
  int          stepof[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, want, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_last[i] = '0; m_high[i] = '0;
      m_mask[i] = '0; m_rep[i]  = '0;
    end
  endtask

  // one sample per cycle: unrolled steps x repeats x phases
  task automatic build(input int ls, input int loops);
    int n;
    wave.delete();
    stepof.delete();
    for (int s = 0; s <= ls; s++)
      for (int r = 0; r <= int'(m_rep[s]); r++)
        for (int p = 0; p <= int'(m_last[s]); p++) begin
          wave.push_back(p < int'(m_high[s]) ? m_mask[s] : 8'h00);
          stepof.push_back(s);
        end
    n = wave.size();
    exp_q.push_back('{8'h00, 1'b1, 1'b0, 2'd0, 1'b1});
    if (loops == 0) begin
      for (int j = 1; j < n; j++)
        exp_q.push_back('{wave[j-1], 1'b1, 1'b0,
                          2'(stepof[j]), 1'b1});
      exp_q.push_back('{wave[n-1], 1'b0, 1'b1, 2'd0, 1'b0});
    end else begin
      for (int j = 1; j <= n * loops; j++)
        exp_q.push_back('{wave[(j-1)%n], 1'b1, (j % n == 0),
                          2'(stepof[j%n]), 1'b1});
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (chk_on) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = '{8'h00, 1'b0, 1'b0, 2'd0, 1'b0};
      chk("pmod", pmod, e.pmod);
      chk("busy", busy, e.busy);
      chk("done", done, e.done);
      chk("cfg_ready", bus.cfg_ready, !e.busy);
      if (e.sv) chk("step", step, e.step);
    end
  end

  task automatic wr(input int a, input int l, input int h,
                    input int m, input int r);
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = 2'(a);
    bus.cfg_last  = 24'(l);
    bus.cfg_high  = 24'(h);
    bus.cfg_mask  = 8'(m);
    bus.cfg_rep   = 8'(r);
    m_last[a] = 24'(l); m_high[a] = 24'(h);
    m_mask[a] = 8'(m);  m_rep[a]  = 8'(r);
    @(posedge clk);
    #1 bus.cfg_valid = 1'b0;
  endtask

  task automatic start_run(input int ls, input int loops);
    last_step = 2'(ls);
    start = 1'b1;
    @(posedge clk);
    build(ls, loops);
    #1 start = 1'b0;
    bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input int want, input string nm);
    int n = 0;
    bit seen = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      n++;
    end
    if (!seen) chk({nm, "_timeout"}, 0, 1);
    else chk(nm, n, want);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.cfg_valid = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_last  = '0;
    bus.cfg_high  = '0;
    bus.cfg_mask  = '0;
    bus.cfg_rep   = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_on = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("rst_step", step, 0);
    end
    @(posedge clk);
    #1;

`ifdef WAVE_SEQ_LOOP_EN
    wr(0, 1, 1, 'hFF, 0);
    start_run(0, 10);
    chk("loop_w0", wave[0], 8'hFF);
    chk("loop_w1", wave[1], 8'h00);
    repeat (12) begin @(posedge clk); #1; end
    stop = 1'b1;
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    @(posedge clk);
    #1 stop = 1'b0;
    @(negedge clk);
    chk("loop_stop_busy", busy, 0);
    @(posedge clk);
    #1;
`else
    // cleared table: single one-cycle step
    start_run(0, 0);
    wait_done(1, "zero_len");

    wr(0, 23, 12, 'h10, 1);
    start_run(0, 0);
    chk("c1_n", wave.size(), 48);
    chk("c1_w11", wave[11], 8'h10);
    chk("c1_w12", wave[12], 8'h00);
    chk("c1_w24", wave[24], 8'h10);
    wait_done(48, "c1_len");

    // stop with writes pending during RUN
    start_run(0, 0);
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = 2'd0;
    bus.cfg_last  = 24'd5;
    bus.cfg_high  = 24'd1;
    bus.cfg_mask  = 8'hFF;
    bus.cfg_rep   = 8'd0;
    repeat (10) begin @(posedge clk); #1; end
    stop = 1'b1;
    bus.cfg_valid = 1'b0;
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    @(posedge clk);
    #1 stop = 1'b0;
    @(negedge clk);
    chk("stop_busy", busy, 0);
    chk("stop_pmod", pmod, 0);
    @(posedge clk);
    #1;
    start_run(0, 0);
    wait_done(48, "rerun_len");

    wr(0, 3, 2, 'h01, 0);
    wr(1, 5, 6, 'h21, 1);
    start_run(1, 0);
    chk("two_n", wave.size(), 16);
    chk("two_s4", stepof[4], 1);
    chk("two_w4", wave[4], 8'h21);
    wait_done(16, "two_len");

    wr(0, 2, 0, 'hFF, 1);
    wr(1, 0, 1, 'h0F, 2);
    start_run(1, 0);
    chk("edge_w0", wave[0], 8'h00);
    chk("edge_w6", wave[6], 8'h0F);
    wait_done(9, "edge_len");

    start = 1'b1;
    stop = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    stop = 1'b0;
    @(negedge clk);
    chk("ss_busy", busy, 0);
    @(posedge clk);
    #1;

    // write-through: entry 0 written on the start edge
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = 2'd0;
    bus.cfg_last  = 24'd1;
    bus.cfg_high  = 24'd1;
    bus.cfg_mask  = 8'h80;
    bus.cfg_rep   = 8'd0;
    m_last[0] = 24'd1; m_high[0] = 24'd1;
    m_mask[0] = 8'h80; m_rep[0]  = 8'd0;
    start_run(0, 0);
    chk("wt_w0", wave[0], 8'h80);
    wait_done(2, "wt_len");

    wr(0, 23, 12, 'h10, 1);
    start_run(0, 0);
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    exp_q.delete();
    model_clear();
    @(negedge clk);
    chk("mrst_pmod", pmod, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_step", step, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    start_run(0, 0);
    wait_done(1, "mrst_len");
`endif

    repeat (3) begin @(posedge clk); #1; end
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pmod_wave_sequencer.md
# pmod_wave_sequencer

Programmable square-wave sequencer driving a bank of PMOD output pins from the on-chip oscillator clock. A small step table holds period, high time, channel mask and repeat count per step. Once started, the block walks the table and emits each step's waveform on the masked pins for the programmed number of periods. It replaces hand-written per-pin divider counters in board top levels.

## Interface
- `CH`, 8, number of output channels (PMOD pins)
- `CNT_W`, 24, width of the period/high-time fields
- `REP_W`, 8, width of the repeat field
- `STEPS`, 4, table depth; must be a power of 2; `SW = $clog2(STEPS)`
- `clk`  in  1  system clock (6 MHz HFOSC in standard builds)
- `rst_n`  in  1  asynchronous active-low reset
- `cfg_valid`  in  1  table-write request
- `cfg_ready`  out  1  table write accepted when `cfg_valid & cfg_ready`
- `cfg_addr`  in  SW  step index to write
- `cfg_last`  in  CNT_W  period minus 1 (phase counts 0..`cfg_last`)
- `cfg_high`  in  CNT_W  pin high while phase < `cfg_high`
- `cfg_mask`  in  CH  channels driven in this step
- `cfg_rep`  in  REP_W  periods in this step, minus 1
- `last_step`  in  SW  final table index; sampled at start
- `start`  in  1  begin sequence (IDLE only)
- `stop`  in  1  abort sequence
- `busy`  out  1  high in RUN
- `step`  out  SW  current step index
- `done`  out  1  one-cycle completion pulse
- `pmod`  out  CH  registered waveform outputs

## Operation
- FSM: IDLE, RUN.
- IDLE:
  - `cfg_ready=1`.
  - Accepted writes store `{last, high, mask, rep}` at `cfg_addr`.
  - `start` (without `stop`) at edge k: latch `last_step`, load entry 0 into working regs, phase=0, rep_cnt=0, `step=0`, state→RUN.
- RUN:
  - `cfg_ready=0`; `cfg_valid` ignored and the table is unchanged.
  - Each cycle: `pmod <= mask & {CH{phase < high}}`.
  - Phase increments, wrapping to 0 after `last`; at wrap, rep_cnt increments.
  - Step end: the cycle with phase==last and rep_cnt==rep.
  - Step end with `step != last_step`: load entry `step+1` into working regs that same edge; phase=0, rep_cnt=0. No gap cycle between steps.
  - Step end with `step == last_step`: end of sequence (see Configuration).
- Arithmetic:
  - `high==0`: pin always low.
  - `high > last`: pin always high.
  - `last==0`: 1-cycle period.
  - Counters unsigned, no saturation.
- `stop` in RUN: state→IDLE, `pmod<=0`, `busy<=0` on that edge.
- `start` in RUN is ignored. `start & stop` together in IDLE: remains IDLE.
- Reset (any time, including mid-run): state IDLE, all outputs 0, table entries 0, working regs 0.

## Timing
- Reset values: `pmod=0`, `busy=0`, `step=0`, `done=0`, `cfg_ready=1`.
- Start latency:
  - `start` sampled at edge k → `busy=1` after edge k.
  - `pmod` shows phase 0 after edge k+1.
- Step steady state: period = last+1 cycles; high for min(high, last+1) cycles per period; step lasts (rep+1)(last+1) cycles.
- `pmod` lags phase by exactly one cycle, including across step boundaries.
- Non-loop end, at the final step-end edge:
  - `busy→0`, `done=1` for one cycle.
  - `pmod` still shows the final phase value for that cycle, then clears to 0 at the next edge.
- Table write takes effect on the accepting edge. A write in the same cycle as `start` is applied before the entry 0 load (write-through).

## Configuration
- `WAVE_SEQ_LOOP_EN` defined:
  - At sequence end, wrap to step 0 (reload entry 0, same-edge, no gap).
  - `busy` stays 1.
  - `done` pulses one cycle on each wrap.
  - Only `stop` or reset exits RUN.
- Not defined: sequence end returns to IDLE as in Timing. The `done` pulse fires once.

## Test plan
- Reset released → `pmod=0`, `busy=0`, `step=0`, `cfg_ready=1`; hold 10 cycles with no change.
- Step0 `{last=23, high=12, mask=8'h10, rep=1}`, `last_step=0`, start (macro off) → `pmod[4]` high 12 / low 12 twice (48 cycles), other pins 0; `done` pulse at the 48th cycle after `busy` rises; `busy=0`; `pmod=0` one cycle later.
- Two steps: step0 `{3,2,8'h01,0}`, step1 `{5,6,8'h21,1}` → 2 high/2 low on bit0, then bits 0 and 5 high for 12 cycles; `step` changes 0→1 with no gap cycle.
- Edge values: `high=0` → masked pins stay 0. `last=0, high=1` → pins constant 1 for rep+1 cycles.
- `stop` asserted 10 cycles into a run → next edge `pmod=0`, `busy=0`. `start` and `stop` in the same IDLE cycle → `busy` stays 0. `cfg_valid` during RUN → `cfg_ready=0`, readback after stop shows the table unchanged.
- `WAVE_SEQ_LOOP_EN`, single step `{1,1,8'hFF,0}` → all pins toggle every cycle indefinitely; `done` pulses every 2 cycles; stop ends the run.
